// File: rtl/hls_macc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hls_macc_sched_pkg
// Brief    : Shared types and constants for the hls_macc round-robin scheduler.
// Revision : 1.0
// ============================================================================
package hls_macc_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

    // Operand slots inside one job word {i6,i4,i3,i2,i1}, in units of DW.
    localparam int OPS_N = 5;
    localparam int OP_I1 = 0;
    localparam int OP_I2 = 1;
    localparam int OP_I3 = 2;
    localparam int OP_I4 = 3;
    localparam int OP_I6 = 4;

    localparam int TIMEOUT_DEF = 64;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hls_macc_rr_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first request after last_i, wrapping.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    int k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        // Offsets start at 1 so the previous winner is considered last.
        for (int off = 1; off <= NREQ; off++) begin
            k = (int'(last_i) + off) % NREQ;
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hls_macc_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : hls_macc_rr_sched
// Brief    : Round-robin scheduler sharing one ap_ctrl_hs macc core, with watchdog.
// Revision : 1.0
// ============================================================================
module hls_macc_rr_sched
    import hls_macc_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*OPS_N*DW-1:0]  req_data,
    output logic                      core_start,
    output logic [OPS_N*DW-1:0]       core_ops,
    input  logic                      core_idle,
    input  logic                      core_done,
    input  logic [DW-1:0]             core_o1,
    input  logic                      core_o1_vld,
    input  logic [DW-1:0]             core_o2,
    input  logic                      core_o2_vld,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [DW-1:0]             rsp_o1,
    output logic [DW-1:0]             rsp_o2,
    output logic                      rsp_err,
    output logic                      busy
);

    localparam int IW  = cnt_w(NREQ);
    localparam int WW  = cnt_w(TIMEOUT);
    localparam int OPW = OPS_N * DW;

    sched_state_e    state_q;
    logic            en_q;
    logic [IW-1:0]   last_q;
    logic [WW-1:0]   wdog_q;
    logic            core_start_q;
    logic [OPW-1:0]  core_ops_q;
    logic [IW-1:0]   rsp_id_q;
    logic [DW-1:0]   rsp_o1_q;
    logic [DW-1:0]   rsp_o2_q;
    logic            rsp_err_q;

    logic [OPW-1:0]  w_slice [NREQ];
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic            w_accept;

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_slice
            assign w_slice[g] = req_data[g*OPW +: OPW];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (w_gnt),
        .idx_o  (w_idx),
        .any_o  (w_any)
    );

    // en_q keeps req_ready low while reset is asserted and on the release cycle.
    assign w_accept  = en_q && (state_q == ST_IDLE) && core_idle && w_any;
    assign req_ready = w_accept ? w_gnt : '0;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= ST_IDLE;
            en_q         <= 1'b0;
            last_q       <= IW'(NREQ - 1);
            wdog_q       <= '0;
            core_start_q <= 1'b0;
            core_ops_q   <= '0;
            rsp_id_q     <= '0;
            rsp_o1_q     <= '0;
            rsp_o2_q     <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            en_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        core_ops_q   <= w_slice[w_idx];
                        rsp_id_q     <= w_idx;
                        last_q       <= w_idx;
                        rsp_o1_q     <= '0;
                        rsp_o2_q     <= '0;
                        rsp_err_q    <= 1'b0;
                        wdog_q       <= '0;
                        core_start_q <= 1'b1;
                        state_q      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (core_o1_vld) rsp_o1_q <= core_o1;
                    if (core_o2_vld) rsp_o2_q <= core_o2;
                    // done has priority over a watchdog expiry in the same cycle
                    if (core_done) begin
                        core_start_q <= 1'b0;
                        state_q      <= ST_RESP;
                    end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                        rsp_err_q    <= 1'b1;
                        core_start_q <= 1'b0;
                        state_q      <= ST_RESP;
                    end else begin
                        wdog_q <= wdog_q + WW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core_start = core_start_q;
    assign core_ops   = core_ops_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_o1     = rsp_o1_q;
    assign rsp_o2     = rsp_o2_q;
    assign rsp_err    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_hls_macc_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_hls_macc_rr_sched
// Brief    : Scoreboard bench for hls_macc_rr_sched with a behavioural macc core stub.
// Revision : 1.0
// ============================================================================
module tb_hls_macc_rr_sched;
    import hls_macc_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int TO   = 16;
    localparam int IW   = 2;
    localparam int OPW  = OPS_N * DW;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] o1;
        logic [DW-1:0] o2;
        logic          err;
    } rsp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OPW-1:0]  req_data = '0;
    logic                 core_start;
    logic [OPW-1:0]       core_ops;
    logic                 core_idle, core_done;
    logic [DW-1:0]        core_o1, core_o2;
    logic                 core_o1_vld, core_o2_vld;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [IW-1:0]        rsp_id;
    logic [DW-1:0]        rsp_o1, rsp_o2;
    logic                 rsp_err, busy;

    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    hls_macc_rr_sched #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TO)) dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .core_start(core_start), .core_ops(core_ops), .core_idle(core_idle),
        .core_done(core_done), .core_o1(core_o1), .core_o1_vld(core_o1_vld),
        .core_o2(core_o2), .core_o2_vld(core_o2_vld),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_o1(rsp_o1), .rsp_o2(rsp_o2), .rsp_err(rsp_err), .busy(busy)
    );

    // ---------------- core stub: ap_ctrl_hs, latency taken from i6 ----------------
    logic          s_busy;
    logic [15:0]   s_cnt, s_lat;
    logic [DW-1:0] noise;
    logic [DW-1:0] op1, op2, op3, op4;

    assign op1         = core_ops[OP_I1*DW +: DW];
    assign op2         = core_ops[OP_I2*DW +: DW];
    assign op3         = core_ops[OP_I3*DW +: DW];
    assign op4         = core_ops[OP_I4*DW +: DW];
    assign core_idle   = !s_busy;
    assign core_done   = s_busy && (s_cnt == s_lat);
    assign core_o2_vld = core_done;
    assign core_o1_vld = s_busy && (s_cnt == s_lat - 16'd1);
    assign core_o1     = core_o1_vld ? op1 * op2 : noise;
    assign core_o2     = core_o2_vld ? op3 + op4 : ~noise;

    always @(posedge clk) noise <= $urandom;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_busy <= 1'b0;
            s_cnt  <= '0;
            s_lat  <= '0;
        end else if (!s_busy) begin
            if (core_start) begin
                s_busy <= 1'b1;
                s_cnt  <= 16'd2;
                s_lat  <= 16'(core_ops[OP_I6*DW +: 6]);
            end
        end else if (core_done) begin
            s_busy <= 1'b0;
        end else begin
            s_cnt <= s_cnt + 16'd1;
        end
    end

    // ---------------- reference model and checking helpers ----------------
    rsp_t exp_q[$];
    int   grant_log[$];
    int   last_m = NREQ - 1;
    bit   inflight = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [OPW-1:0] mk_job(input logic [DW-1:0] a, b, c, e, input int lat);
        return {DW'(lat), e, c, b, a};
    endfunction

    // A job's outcome follows from its latency L versus the watchdog budget:
    // o1 arrives in RUN cycle L-1, o2 and done in RUN cycle L, abort after TO cycles.
    function automatic rsp_t model(input int id, input logic [OPW-1:0] d);
        rsp_t r;
        int   lat;
        logic [DW-1:0] a, b, c, e;
        a   = d[OP_I1*DW +: DW];
        b   = d[OP_I2*DW +: DW];
        c   = d[OP_I3*DW +: DW];
        e   = d[OP_I4*DW +: DW];
        lat = int'(d[OP_I6*DW +: 6]);
        r.id  = IW'(id);
        r.err = (lat > TO);
        r.o1  = (lat - 1 <= TO) ? a * b : '0;
        r.o2  = (lat <= TO) ? c + e : '0;
        return r;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int off = 1; off <= NREQ; off++)
            if (v[(last + off) % NREQ]) return (last + off) % NREQ;
        return -1;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int   m_g;
    rsp_t m_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != '0) begin
                m_g = rr_pick(req_valid, last_m);
                if (m_g < 0) begin
                    chk("grant_without_valid", 128'(req_ready), 128'(0));
                end else begin
                    chk("grant_onehot", 128'(req_ready), 128'(1) << m_g);
                    chk("grant_while_inflight", 128'(inflight), 128'(0));
                    chk("grant_core_idle", 128'(core_idle), 128'(1));
                    last_m   = m_g;
                    inflight = 1'b1;
                    grant_log.push_back(m_g);
                    exp_q.push_back(model(m_g, req_data[m_g*OPW +: OPW]));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 128'(rsp_valid), 128'(0));
                end else begin
                    m_e = exp_q.pop_front();
                    chk("rsp_fields", 128'({rsp_id, rsp_o1, rsp_o2, rsp_err}), 128'(m_e));
                    inflight = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int k, output int cyc);
        int c;
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (req_ready[k]) break;
        end
        chk("accept_in_budget", 128'(c < 100), 128'(1));
        cyc = c;
        tick();
        req_valid[k] = 1'b0;
    endtask

    task automatic drain(input string nm);
        int c;
        c = 0;
        while (c < 400 && (busy || !core_idle || exp_q.size() != 0)) begin
            tick();
            c++;
        end
        chk(nm, 128'({busy, !core_idle, exp_q.size() != 0}), 128'(0));
    endtask

    initial begin
        int cyc, runc, changes, pulses;
        logic [127:0] snap;
        int fair_exp[5];
        int lats[3];

        fair_exp = '{1, 2, 3, 0, 1};
        lats     = '{15, 16, 17};

        // Reset with every requester valid: no accept may leak out.
        for (int k = 0; k < NREQ; k++) req_data[k*OPW +: OPW] = mk_job(DW'(k+1), DW'(k+2), DW'(k+3), DW'(k+4), 4);
        req_valid = '1;
        repeat (3) tick();
        chk("rst_ctrl", 128'({req_ready, core_start, rsp_valid, rsp_err, busy}), 128'(0));
        chk("rst_ops", 128'(|core_ops), 128'(0));
        chk("rst_rsp", 128'({rsp_id, rsp_o1, rsp_o2}), 128'(0));
        req_valid = '0;
        rst_n = 1'b1;
        tick();
        tick();

        // Single job: accept cycle 0, core_start 1..4, response cycle 5.
        req_data[0 +: OPW] = mk_job(3, 5, 7, 9, 4);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("single_accept", 128'(req_ready), 128'(4'b0001));
        tick();
        req_valid = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("single_core_start", 128'(core_start), 128'(c <= 4));
            chk("single_rsp_valid", 128'(rsp_valid), 128'(c == 5));
            if (c == 5)
                chk("single_rsp", 128'({rsp_id, rsp_o1, rsp_o2, rsp_err}), 128'({2'd0, 32'd15, 32'd16, 1'b0}));
            tick();
        end
        drain("single_drain");

        // Fairness: all requesters valid continuously, order continues after 0.
        for (int k = 0; k < NREQ; k++) req_data[k*OPW +: OPW] = mk_job(DW'(10*k+1), DW'(10*k+2), DW'(k), 100, 4);
        grant_log.delete();
        req_valid = '1;
        for (int c = 0; c < 200 && grant_log.size() < 5; c++) tick();
        req_valid = '0;
        chk("fair_count", 128'(grant_log.size()), 128'(5));
        for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("fair_order", 128'(grant_log[i]), 128'(fair_exp[i]));
        drain("fair_drain");

        // Backpressure: response held stable and no new grants while stalled.
        rsp_ready = 1'b0;
        req_data[2*OPW +: OPW] = mk_job(11, 12, 13, 14, 5);
        req_data[1*OPW +: OPW] = mk_job(21, 22, 23, 24, 4);
        req_valid = 4'b0110;
        wait_accept(2, cyc);
        for (cyc = 0; cyc < 50 && !rsp_valid; cyc++) tick();
        @(negedge clk);
        snap = 128'({rsp_id, rsp_o1, rsp_o2, rsp_err});
        changes = 0;
        pulses = 0;
        repeat (10) begin
            tick();
            @(negedge clk);
            if (128'({rsp_id, rsp_o1, rsp_o2, rsp_err}) !== snap || !rsp_valid) changes++;
            if (req_ready != '0) pulses++;
        end
        chk("bp_stable", 128'(changes), 128'(0));
        chk("bp_no_grant", 128'(pulses), 128'(0));
        chk("bp_snapshot", snap, 128'({2'd2, 32'd132, 32'd27, 1'b0}));
        tick();
        rsp_ready = 1'b1;
        wait_accept(1, cyc);
        drain("bp_drain");

        // Watchdog: core hangs far beyond the budget.
        req_data[3*OPW +: OPW] = mk_job(2, 3, 4, 5, 40);
        req_valid = 4'b1000;
        wait_accept(3, cyc);
        runc = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rsp_valid) break;
            runc += int'(core_start);
        end
        chk("wd_run_cycles", 128'(runc), 128'(TO));
        chk("wd_start_low", 128'(core_start), 128'(0));
        chk("wd_err", 128'(rsp_err), 128'(1));
        chk("wd_core_still_busy", 128'(core_idle), 128'(0));
        tick();
        req_data[0 +: OPW] = mk_job(6, 7, 8, 9, 4);
        req_valid = 4'b0001;
        wait_accept(0, cyc);
        chk("wd_grant_blocked", 128'(cyc >= 20), 128'(1));
        drain("wd_drain");

        // Latency around the watchdog boundary (done+timeout coincide at TO).
        foreach (lats[i]) begin
            req_data[1*OPW +: OPW] = mk_job($urandom, $urandom, $urandom, $urandom, lats[i]);
            req_valid = 4'b0010;
            wait_accept(1, cyc);
            drain("edge_drain");
        end

        // Randomised traffic with random backpressure.
        for (int n = 0; n < 1500; n++) begin
            logic [NREQ-1:0] acc;
            @(negedge clk);
            acc = req_ready & req_valid;
            tick();
            for (int k = 0; k < NREQ; k++) begin
                if (acc[k]) begin
                    req_valid[k] = 1'b0;
                end else if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
                    req_data[k*OPW +: OPW] = mk_job($urandom, $urandom_range(0, 1000),
                                                    $urandom, $urandom, int'($urandom_range(3, 20)));
                    req_valid[k] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        drain("rand_drain");

        // Asynchronous reset in the middle of RUN.
        req_data[2*OPW +: OPW] = mk_job(1, 2, 3, 4, 10);
        req_valid = 4'b0100;
        wait_accept(2, cyc);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", 128'({req_ready, core_start, rsp_valid, rsp_err, busy}), 128'(0));
        chk("arst_ops", 128'(|core_ops), 128'(0));
        chk("arst_rsp", 128'({rsp_id, rsp_o1, rsp_o2}), 128'(0));
        exp_q.delete();
        last_m   = NREQ - 1;
        inflight = 1'b0;
        for (int k = 0; k < NREQ; k++) req_data[k*OPW +: OPW] = mk_job(DW'(k), 3, DW'(k), 5, 4);
        req_valid = '1;
        repeat (3) tick();
        chk("arst_hold", 128'({rsp_valid, busy, core_start, req_ready}), 128'(0));
        rst_n = 1'b1;
        for (cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (req_ready != '0) break;
        end
        chk("arst_first_grant", 128'(req_ready), 128'(4'b0001));
        tick();
        req_valid = '0;
        drain("arst_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
